// File: rtl/demux_pkg.sv
// demux_pkg: shared sizing and FSM state type for the demux scan sequencer
`timescale 1ns/1ps
package demux_pkg;
  localparam int SEL_W_DEF = 3;
  localparam int N_CH_DEF = 2**SEL_W_DEF;
  typedef enum logic {IDLE, SCAN} state_t;
endpackage

// File: rtl/demux_next_ch.sv
// demux_next_ch: finds the lowest set mask bit at or after a start point
`timescale 1ns/1ps
module demux_next_ch #(
  parameter int SEL_W = 3,
  localparam int N_CH = 2**SEL_W
) (
  input  logic [N_CH-1:0]  mask,
  input  logic [SEL_W-1:0] idx,
  input  logic             first,
  output logic [SEL_W-1:0] nxt,
  output logic             found
);
  always_comb begin
    nxt = '0;
    found = 1'b0;
    for (int k = N_CH - 1; k >= 0; k--)
      if (mask[k] && (first || k > int'(idx))) begin
        nxt = k[SEL_W-1:0];
        found = 1'b1;
      end
  end
endmodule

// File: rtl/demux_scan_sequencer.sv
// demux_scan_sequencer: walks enabled channels of a captured word, presenting sel/bit for HOLD cycles each
`timescale 1ns/1ps
module demux_scan_sequencer
  import demux_pkg::*;
#(
  parameter int SEL_W = SEL_W_DEF,
  parameter int HOLD = 1,
  localparam int N_CH = 2**SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_CH-1:0]  in_data,
  input  logic [N_CH-1:0]  in_mask,
  output logic [SEL_W-1:0] sel,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             done
);
  state_t state;
  logic [N_CH-1:0] data_q, mask_q;
  logic [7:0] cnt;
  logic [SEL_W-1:0] nxt;
  logic found;
  assign in_ready = state == IDLE;
  // In IDLE the search covers the incoming mask from bit 0; in SCAN it looks strictly above sel
  demux_next_ch #(.SEL_W(SEL_W)) u_next (
    .mask(in_ready ? in_mask : mask_q),
    .idx(sel),
    .first(in_ready),
    .nxt(nxt),
    .found(found)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      data_q <= '0;
      mask_q <= '0;
      cnt <= '0;
      sel <= '0;
      bit_out <= 1'b0;
      bit_valid <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        bit_valid <= 1'b0;
        bit_out <= 1'b0;
        if (in_valid) begin
          data_q <= in_data;
          mask_q <= in_mask;
          if (found) begin
            state <= SCAN;
            sel <= nxt;
            bit_out <= in_data[nxt];
            bit_valid <= 1'b1;
            cnt <= 8'd1;
          end else
            done <= 1'b1;
        end
      end else if (cnt < 8'(HOLD))
        cnt <= cnt + 8'd1;
      else if (found) begin
        sel <= nxt;
        bit_out <= data_q[nxt];
        cnt <= 8'd1;
      end else begin
        state <= IDLE;
        bit_valid <= 1'b0;
        bit_out <= 1'b0;
        done <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_demux_scan_sequencer.sv
// tb_demux_scan_sequencer: vector table plus scoreboard check of the scan sequencer at HOLD=1 and HOLD=2
`timescale 1ns/1ps
module tb_demux_scan_sequencer;
  typedef struct {logic done; logic [2:0] sel; logic b;} ev_t;
  typedef struct {int which; logic [7:0] d; logic [7:0] m; int exp_valid; int exp_done;} vec_t;
  logic clk = 1'b0, rst_n = 1'b1;
  logic v1 = 1'b0, v2 = 1'b0;
  logic [7:0] d1 = '0, m1 = '0, d2 = '0, m2 = '0;
  logic r1, bo1, bv1, dn1, r2, bo2, bv2, dn2;
  logic [2:0] s1, s2;
  ev_t q1[$], q2[$];
  int tests = 0, fails = 0;
  always #5 clk = ~clk;

  demux_scan_sequencer #(.SEL_W(3), .HOLD(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(r1), .in_data(d1), .in_mask(m1),
    .sel(s1), .bit_out(bo1), .bit_valid(bv1), .done(dn1));
  demux_scan_sequencer #(.SEL_W(3), .HOLD(2)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(r2), .in_data(d2), .in_mask(m2),
    .sel(s2), .bit_out(bo2), .bit_valid(bv2), .done(dn2));

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask

  task automatic push_word(int which, logic [7:0] d, logic [7:0] m);
    int hold = which == 1 ? 1 : 2;
    for (int k = 0; k < 8; k++)
      if (m[k])
        for (int h = 0; h < hold; h++)
          if (which == 1) q1.push_back('{1'b0, 3'(k), d[k]});
          else q2.push_back('{1'b0, 3'(k), d[k]});
    if (which == 1) q1.push_back('{1'b1, 3'd0, 1'b0});
    else q2.push_back('{1'b1, 3'd0, 1'b0});
  endtask

  // Every valid or done cycle must match the next expected event in order
  always @(negedge clk) if (rst_n) begin
    ev_t e;
    chk("u1_ready", r1, !bv1);
    chk("u2_ready", r2, !bv2);
    if (!bv1) chk("u1_bit_idle", bo1, 0);
    if (!bv2) chk("u2_bit_idle", bo2, 0);
    if (bv1 || dn1) begin
      if (q1.size() == 0) begin
        tests++; fails++;
        $display("FAIL u1_unexpected: sel=%0d valid=%0b done=%0b with nothing expected", s1, bv1, dn1);
      end else begin
        e = q1.pop_front();
        chk("u1_done", dn1, e.done);
        chk("u1_valid", bv1, !e.done);
        if (!e.done) begin
          chk("u1_sel", s1, e.sel);
          chk("u1_bit", bo1, e.b);
        end
      end
    end
    if (bv2 || dn2) begin
      if (q2.size() == 0) begin
        tests++; fails++;
        $display("FAIL u2_unexpected: sel=%0d valid=%0b done=%0b with nothing expected", s2, bv2, dn2);
      end else begin
        e = q2.pop_front();
        chk("u2_done", dn2, e.done);
        chk("u2_valid", bv2, !e.done);
        if (!e.done) begin
          chk("u2_sel", s2, e.sel);
          chk("u2_bit", bo2, e.b);
        end
      end
    end
  end

  task automatic run_word(vec_t t);
    int nv = 0, at = -1;
    @(negedge clk);
    if (t.which == 1) begin v1 = 1'b1; d1 = t.d; m1 = t.m; end
    else begin v2 = 1'b1; d2 = t.d; m2 = t.m; end
    push_word(t.which, t.d, t.m);
    @(posedge clk);
    #1 v1 = 1'b0; v2 = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (t.which == 1 ? bv1 : bv2) nv++;
      if (t.which == 1 ? dn1 : dn2) begin at = c; break; end
    end
    chk($sformatf("valid_cycles m=%h", t.m), nv, t.exp_valid);
    chk($sformatf("done_cycle m=%h", t.m), at, t.exp_done);
  endtask

  initial begin
    vec_t tbl[8];
    int at;
    tbl[0] = '{1, 8'hA6, 8'hFF, 8, 9};
    tbl[1] = '{2, 8'hFF, 8'h85, 6, 7};
    tbl[2] = '{1, 8'hA5, 8'h00, 0, 1};
    tbl[3] = '{2, 8'hA5, 8'h00, 0, 1};
    tbl[4] = '{2, 8'h3C, 8'h18, 4, 5};
    tbl[5] = '{1, 8'h5A, 8'h80, 1, 2};
    tbl[6] = '{1, 8'h0F, 8'h01, 1, 2};
    tbl[7] = '{2, 8'h96, 8'h7E, 12, 13};
    #1 rst_n = 1'b0;
    #1;
    chk("rst_sel", s1, 0); chk("rst_valid", bv1, 0); chk("rst_done", dn1, 0);
    chk("rst_bit", bo1, 0); chk("rst_ready", r1, 1); chk("rst_ready2", r2, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    foreach (tbl[i]) run_word(tbl[i]);

    // Back-to-back: in_valid stays high; word B offered during A's scan is taken only at A's done edge
    @(negedge clk);
    v1 = 1'b1; d1 = 8'h02; m1 = 8'h03;
    push_word(1, 8'h02, 8'h03);
    @(posedge clk);
    #1 d1 = 8'h80; m1 = 8'h80;
    push_word(1, 8'h80, 8'h80);
    at = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (dn1) begin at = c; break; end
    end
    chk("b2b_done_a", at, 3);
    @(posedge clk);
    #1 v1 = 1'b0;
    at = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) chk("b2b_sel_b", s1, 7);
      if (dn1) begin at = c; break; end
    end
    chk("b2b_done_b", at, 2);

    // Asynchronous reset at the 3rd valid cycle of a full scan
    @(negedge clk);
    v1 = 1'b1; d1 = 8'hFF; m1 = 8'hFF;
    push_word(1, 8'hFF, 8'hFF);
    @(posedge clk);
    #1 v1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_sel", s1, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sel", s1, 0); chk("arst_bit", bo1, 0); chk("arst_valid", bv1, 0);
    chk("arst_done", dn1, 0); chk("arst_ready", r1, 1);
    q1.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    run_word('{1, 8'h10, 8'h10, 1, 2});
    repeat (3) @(negedge clk);
    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
